// File: rtl/tetris_pkg.sv
// Shared board geometry, cell layout helper and clear-pass FSM encoding.
package tetris_pkg;

    localparam int COLS       = 10;
    localparam int ROWS       = 20;
    localparam int CW         = 4;
    localparam int BW         = 1024;
    localparam int ROW_BITS   = COLS * CW;
    localparam int BOARD_BITS = ROWS * ROW_BITS;
    localparam int PTR_W      = 5;
    localparam int CNT_W      = 3;

    localparam logic [CW-1:0] EMPTY_CELL = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Bit offset of cell (x,y) inside a packed board; row 0 is the top row.
    function automatic int cell_index(input int x, input int y);
        return (y * COLS + x) * CW;
    endfunction

endpackage

// File: rtl/board_line_clear_if.sv
// Request/result bundle between the game FSM and the line-clear engine.
interface board_line_clear_if;
    import tetris_pkg::*;

    logic                 start;
    logic [BW-1:0]        board_in;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     lines_cleared;
    logic [BW-1:0]        board_out;

    modport master (
        output start,
        output board_in,
        input  busy,
        input  done,
        input  lines_cleared,
        input  board_out
    );

    modport slave (
        input  start,
        input  board_in,
        output busy,
        output done,
        output lines_cleared,
        output board_out
    );

endinterface

// File: rtl/row_full_detect.sv
// Combinational check that every cell of one board row is occupied.
module row_full_detect
    import tetris_pkg::*;
(
    input  logic [ROW_BITS-1:0] row_bits,
    output logic                full
);

    // A single empty cell anywhere in the row makes it not full.
    always_comb begin
        full = 1'b1;
        for (int x = 0; x < COLS; x++) begin
            if (row_bits[cell_index(x, 0) +: CW] == EMPTY_CELL) begin
                full = 1'b0;
            end
        end
    end

endmodule

// File: rtl/board_line_clear.sv
// Row-clear sequencer: snapshots the locked board, removes full rows
// bottom-up by shifting one row per cycle, and keeps a frame-synchronous
// copy of the result for the renderer.
module board_line_clear
    import tetris_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    board_line_clear_if.slave   bus,
    input  logic                i_sync_vs,
    output logic [BW-1:0]       disp_board
);

    state_t                 state;
    state_t                 state_next;

    logic [BOARD_BITS-1:0]  work;
    logic [PTR_W-1:0]       row;
    logic [PTR_W-1:0]       sp;
    logic [CNT_W-1:0]       cnt;

    logic [BW-1:0]          board_out_q;
    logic [CNT_W-1:0]       lines_q;

    logic                   vs_q;
    logic                   vs_rise;

    logic [ROW_BITS-1:0]    sel_row;
    logic                   row_full;

    // Padding bits above the real board are never stored; this just
    // acknowledges that they are intentionally dropped.
    logic                   unused_upper;
    assign unused_upper = ^bus.board_in[BW-1:BOARD_BITS];

    // Row currently under inspection, fed to the full-row detector.
    always_comb begin
        sel_row = work[ROW_BITS * int'(row) +: ROW_BITS];
    end

    row_full_detect u_detect (
        .row_bits (sel_row),
        .full     (row_full)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection plus the status outputs derived from state.
    always_comb begin
        state_next = state;
        bus.busy   = (state != ST_IDLE);
        bus.done   = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (row_full) begin
                    state_next = ST_SHIFT;
                end else if (row == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (sp == '0) begin
                    state_next = ST_CHECK;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Work board, scan pointers and result registers. The result is
    // captured on the edge that enters DONE so it is already valid in the
    // cycle where done is high; CHECK never modifies work, so this is the
    // final board.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work        <= '0;
            row         <= '0;
            sp          <= '0;
            cnt         <= '0;
            board_out_q <= '0;
            lines_q     <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    work <= bus.board_in[BOARD_BITS-1:0];
                    row  <= PTR_W'(ROWS - 1);
                    cnt  <= '0;
                end
                ST_CHECK: begin
                    if (row_full) begin
                        sp  <= row;
                        cnt <= (cnt == 3'd7) ? cnt : cnt + 3'd1;
                    end else if (row == '0) begin
                        board_out_q <= {{(BW - BOARD_BITS){1'b0}}, work};
                        lines_q     <= cnt;
                    end else begin
                        row <= row - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (sp != '0) begin
                        work[ROW_BITS * int'(sp) +: ROW_BITS] <=
                            work[ROW_BITS * (int'(sp) - 1) +: ROW_BITS];
                        sp <= sp - 1'b1;
                    end else begin
                        work[0 +: ROW_BITS] <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.board_out     = board_out_q;
    assign bus.lines_cleared = lines_q;

    // Vertical-sync edge detect.
    assign vs_rise = i_sync_vs & ~vs_q;

    // Renderer copy only moves on a frame boundary while no pass is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q       <= 1'b0;
            disp_board <= '0;
        end else begin
            vs_q <= i_sync_vs;
            if (vs_rise && (state == ST_IDLE)) begin
                disp_board <= board_out_q;
            end
        end
    end

endmodule
